// File: rtl/pool1_ctrl.sv
// pool1_ctrl: sequencing for the first max-pool layer.
// Walks the 28x28 conv1 map in f2 in 2x2 window order, drives load/last
// strobes aligned to f2 read data, writes the 14x14 result addresses into f3
// and pulses done once the final pooled pixel has been written.
// Optional build macro POOL1_PERF_CNT_EN adds a RUN-cycle counter output
// (pool1_cycles).
module pool1_ctrl #(
  parameter int IN_W    = 28,
  parameter int RADDR_W = 10,
  parameter int WADDR_W = 8,
  parameter int RD_LAT  = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pool1_start,
  output logic [RADDR_W-1:0] f2_raddr,
  output logic               f2_rd_en,
  output logic               pool1_load,
  output logic               pool1_last,
  output logic [WADDR_W-1:0] f3_waddr,
  output logic               f3_wr_en,
  output logic               pool1_busy,
  output logic               pool1_done
`ifdef POOL1_PERF_CNT_EN
  ,
  output logic [15:0]        pool1_cycles
`endif
);

  localparam int OUT_W = IN_W / 2;
  localparam int CW    = (OUT_W > 1) ? $clog2(OUT_W) : 1;

  typedef enum logic [2:0] {
    IDLE = 3'b001,
    RUN  = 3'b010,
    DONE = 3'b100
  } state_t;

  state_t state, state_nxt;

  logic          cnt0, cnt1;
  logic [CW-1:0] cnt2, cnt3;
  logic          run;
  logic          cnt0_end, cnt1_end, cnt2_end, cnt3_end;
  logic          load_p0, last_p0;
  logic [RADDR_W-1:0] raddr_p0;
  logic [WADDR_W-1:0] waddr_p0;

  // Strobe/address delay lines; index k holds the value k+1 cycles after the counters.
  logic [RD_LAT:0]    load_p;
  logic [RD_LAT:0]    last_p;
  logic [WADDR_W-1:0] waddr_p [RD_LAT+1];
  logic [RD_LAT+1:0]  done_p;

  assign run        = (state == RUN);
  assign pool1_busy = run;

  // Counter carry chain: window col -> window row -> out col -> out row.
  assign cnt0_end = run & cnt0;
  assign cnt1_end = cnt0_end & cnt1;
  assign cnt2_end = cnt1_end & (cnt2 == CW'(OUT_W - 1));
  assign cnt3_end = cnt2_end & (cnt3 == CW'(OUT_W - 1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; start only matters while idle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pool1_start) state_nxt = RUN;
      RUN:     if (cnt3_end)    state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Window/output counters, advancing only while running.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0 <= 1'b0;
      cnt1 <= 1'b0;
      cnt2 <= '0;
      cnt3 <= '0;
    end else if (run) begin
      cnt0 <= ~cnt0;
      if (cnt0_end) cnt1 <= ~cnt1;
      if (cnt1_end) cnt2 <= cnt2_end ? '0 : cnt2 + CW'(1);
      if (cnt2_end) cnt3 <= cnt3_end ? '0 : cnt3 + CW'(1);
    end
  end

  // Stage p0: combinational address and strobe generation from the counters.
  always_comb begin
    raddr_p0 = ((RADDR_W'(cnt3) << 1) + RADDR_W'(cnt1)) * RADDR_W'(IN_W)
             + (RADDR_W'(cnt2) << 1) + RADDR_W'(cnt0);
    waddr_p0 = WADDR_W'(cnt3) * WADDR_W'(OUT_W) + WADDR_W'(cnt2);
    load_p0  = run & ~cnt0 & ~cnt1;
    last_p0  = run &  cnt0 &  cnt1;
  end

  // Stage p1: registered f2 read address and enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f2_raddr <= '0;
      f2_rd_en <= 1'b0;
    end else begin
      f2_raddr <= raddr_p0;
      f2_rd_en <= run;
    end
  end

  // Stages p1..p(1+RD_LAT): carry strobes and f3 address alongside the read latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_p <= '0;
      last_p <= '0;
      for (int i = 0; i <= RD_LAT; i++) waddr_p[i] <= '0;
    end else begin
      load_p     <= {load_p[RD_LAT-1:0], load_p0};
      last_p     <= {last_p[RD_LAT-1:0], last_p0};
      waddr_p[0] <= waddr_p0;
      for (int i = 1; i <= RD_LAT; i++) waddr_p[i] <= waddr_p[i-1];
    end
  end

  assign pool1_load = load_p[RD_LAT];
  assign pool1_last = last_p[RD_LAT];

  // Stage p(2+RD_LAT): write the pooled pixel once the datapath has latched its max.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f3_wr_en <= 1'b0;
      f3_waddr <= '0;
    end else begin
      f3_wr_en <= last_p[RD_LAT];
      if (last_p[RD_LAT]) f3_waddr <= waddr_p[RD_LAT];
    end
  end

  // Done pulse trails DONE so it lands one cycle after the final f3 write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) done_p <= '0;
    else        done_p <= {done_p[RD_LAT:0], (state == DONE)};
  end

  assign pool1_done = done_p[RD_LAT+1];

`ifdef POOL1_PERF_CNT_EN
  // RUN-cycle counter: cleared on start, held after the run ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                            pool1_cycles <= '0;
    else if ((state == IDLE) && pool1_start) pool1_cycles <= '0;
    else if (run)                          pool1_cycles <= pool1_cycles + 16'd1;
  end
`endif

endmodule

// File: tb/tb_pool1_ctrl.sv
// tb_pool1_ctrl: directed self-checking bench for pool1_ctrl.
// Cycle numbers (rel) count from the cycle in which pool1_start is sampled.
module tb_pool1_ctrl;

  localparam int IN_W    = 28;
  localparam int RADDR_W = 10;
  localparam int WADDR_W = 8;
  localparam int RD_LAT  = 2;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               pool1_start = 1'b0;
  logic [RADDR_W-1:0] f2_raddr;
  logic               f2_rd_en;
  logic               pool1_load;
  logic               pool1_last;
  logic [WADDR_W-1:0] f3_waddr;
  logic               f3_wr_en;
  logic               pool1_busy;
  logic               pool1_done;
`ifdef POOL1_PERF_CNT_EN
  logic [15:0]        pool1_cycles;
`endif

  pool1_ctrl #(
    .IN_W(IN_W), .RADDR_W(RADDR_W), .WADDR_W(WADDR_W), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .pool1_start(pool1_start),
    .f2_raddr(f2_raddr),
    .f2_rd_en(f2_rd_en),
    .pool1_load(pool1_load),
    .pool1_last(pool1_last),
    .f3_waddr(f3_waddr),
    .f3_wr_en(f3_wr_en),
    .pool1_busy(pool1_busy),
    .pool1_done(pool1_done)
`ifdef POOL1_PERF_CNT_EN
    ,
    .pool1_cycles(pool1_cycles)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int rel = 0;
  int wr_cnt = 0;
  int done_cnt = 0;
  int done_rel = -1;

  int first_addr [8] = '{0, 1, 28, 29, 2, 3, 30, 31};
  int last_addr  [4] = '{754, 755, 782, 783};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @rel %0d: got %0d expected %0d", tag, rel, got, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_raddr"}, f2_raddr, 0);
    check_eq({tag, "_rd_en"}, f2_rd_en, 0);
    check_eq({tag, "_load"},  pool1_load, 0);
    check_eq({tag, "_last"},  pool1_last, 0);
    check_eq({tag, "_waddr"}, f3_waddr, 0);
    check_eq({tag, "_wr_en"}, f3_wr_en, 0);
    check_eq({tag, "_busy"},  pool1_busy, 0);
    check_eq({tag, "_done"},  pool1_done, 0);
  endtask

  // Advance one cycle, sample at the falling edge, track writes and done pulses.
  task automatic tick();
    @(negedge clk);
    rel++;
    if (f3_wr_en) begin
      check_eq("waddr_seq", f3_waddr, wr_cnt);
      wr_cnt++;
    end
    if (pool1_done) begin
      done_cnt++;
      done_rel = rel;
    end
  endtask

  // Raise start for the cycle that becomes rel 0.
  task automatic begin_run();
    @(negedge clk);
    pool1_start = 1'b1;
    rel = 0;
    wr_cnt = 0;
    done_cnt = 0;
    done_rel = -1;
  endtask

  initial begin
    // Reset state
    #1;
    check_idle_outputs("rst_async");
    repeat (3) @(negedge clk);
    check_idle_outputs("rst_held");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_idle_outputs("post_rst");

    // Full run with a one-cycle start pulse, strobes checked every cycle
    begin_run();
    check_eq("busy_c0", pool1_busy, 0);
    while (rel < 795) begin
      tick();
      if (rel == 1) pool1_start = 1'b0;
      check_eq("busy",  pool1_busy, (rel >= 1 && rel <= 784));
      check_eq("rd_en", f2_rd_en,   (rel >= 2 && rel <= 785));
      check_eq("load",  pool1_load, (rel >= 4 && rel <= 784 && (rel % 4) == 0));
      check_eq("last",  pool1_last, (rel >= 7 && rel <= 787 && (rel % 4) == 3));
      check_eq("wr_en", f3_wr_en,   (rel >= 8 && rel <= 788 && (rel % 4) == 0));
      check_eq("done",  pool1_done, (rel == 789));
      if (rel >= 2 && rel <= 9)     check_eq("raddr_first", f2_raddr, first_addr[rel-2]);
      if (rel >= 782 && rel <= 785) check_eq("raddr_last",  f2_raddr, last_addr[rel-782]);
      if (rel == 8)  check_eq("waddr_w0", f3_waddr, 0);
      if (rel == 12) check_eq("waddr_w1", f3_waddr, 1);
    end
    check_eq("wr_total",   wr_cnt,   196);
    check_eq("done_count", done_cnt, 1);
    check_eq("done_cycle", done_rel, 789);
    check_eq("waddr_hold", f3_waddr, 195);
`ifdef POOL1_PERF_CNT_EN
    check_eq("perf_cycles", pool1_cycles, 784);
    repeat (5) tick();
    check_eq("perf_hold", pool1_cycles, 784);
`endif

    // Start pulsed repeatedly during RUN and once in DONE: ignored
    begin_run();
    while (rel < 900) begin
      tick();
      pool1_start = ((rel < 780) && (rel % 50 == 0)) || (rel == 785);
    end
    pool1_start = 1'b0;
    check_eq("spam_wr_total", wr_cnt,   196);
    check_eq("spam_done_cnt", done_cnt, 1);
    check_eq("spam_done_rel", done_rel, 789);
    check_eq("spam_idle",     pool1_busy, 0);

    // Start held high: restart straight after DONE
    begin_run();
    while (rel < 789) begin
      tick();
      if (rel == 785) check_eq("hold_busy_done", pool1_busy, 0);
      if (rel == 786) check_eq("hold_busy_idle", pool1_busy, 0);
      if (rel == 787) check_eq("hold_busy_run2", pool1_busy, 1);
      if (rel == 787) check_eq("hold_rd_en_off", f2_rd_en, 0);
      if (rel == 788) check_eq("hold_rd_en_on",  f2_rd_en, 1);
      if (rel == 788) check_eq("hold_raddr0",    f2_raddr, 0);
      if (rel == 789) check_eq("hold_raddr1",    f2_raddr, 1);
    end
    check_eq("hold_done1", done_rel, 789);
    pool1_start = 1'b0;
    wr_cnt = 0;
    while (rel < 1600) tick();
    check_eq("hold_done_cnt", done_cnt, 2);
    check_eq("hold_done2",    done_rel, 1575);
    check_eq("hold_wr_run2",  wr_cnt,   196);

    // Reset in the middle of a run aborts it
    begin_run();
    while (rel < 300) begin
      tick();
      if (rel == 1) pool1_start = 1'b0;
    end
    check_eq("mid_busy_before", pool1_busy, 1);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("mid_rst");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    wr_cnt = 0;
    repeat (900) tick();
    check_eq("abort_no_done",  done_cnt, 0);
    check_eq("abort_no_write", wr_cnt,   0);
    check_eq("abort_idle",     pool1_busy, 0);

    // Clean run after the abort
    begin_run();
    while (rel < 795) begin
      tick();
      if (rel == 1) pool1_start = 1'b0;
      if (rel == 1) check_eq("re_busy", pool1_busy, 1);
      if (rel >= 2 && rel <= 5) check_eq("re_raddr", f2_raddr, first_addr[rel-2]);
    end
    check_eq("re_wr_total", wr_cnt,   196);
    check_eq("re_done_cnt", done_cnt, 1);
    check_eq("re_done_rel", done_rel, 789);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
